microwave_ctrl: RTL and testbench

- Top-level sequencer for the microwave countdown timer.
- Converts front-panel buttons, door sensor and power setting into single-cycle start/stop/pause commands and a clamped min/sec preset for the timer.
- Gates the magnetron with a power-level duty cycle, drives the cavity lamp, and runs the end-of-cook beeper.
- Sits between the panel inputs and the timer and display path.

---
 rtl/mw_pkg.sv | 47 ++++
 rtl/mw_sec_tick.sv | 36 +++
 rtl/microwave_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_microwave_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mw_pkg.sv
// Shared definitions for the microwave controller.
//   - mw_state_t : FSM state encoding (also driven out on the debug state port)
//   - MAX_MIN / MAX_SEC : upper bounds of a min:sec preset
//   - mw_clamp   : clamp raw switch values into a legal min:sec preset
//   - mw_sat_add : add seconds to a min:sec preset with carry, saturating at 99:59
package mw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_COOK   = 3'd1,
        ST_PAUSED = 3'd2,
        ST_FINISH = 3'd3
    } mw_state_t;

    localparam logic [6:0] MAX_MIN = 7'd99;
    localparam logic [6:0] MAX_SEC = 7'd59;

    typedef struct packed {
        logic [6:0] min;
        logic [6:0] sec;
    } mw_time_t;

    function automatic mw_time_t mw_clamp(input logic [6:0] min_in, input logic [6:0] sec_in);
        mw_time_t r;
        r.min = (min_in > MAX_MIN) ? MAX_MIN : min_in;
        r.sec = (sec_in > MAX_SEC) ? MAX_SEC : sec_in;
        return r;
    endfunction

    // Works in total seconds so any step size carries correctly into minutes.
    function automatic mw_time_t mw_sat_add(input mw_time_t t, input logic [6:0] add_sec);
        logic [13:0] total;
        logic [13:0] limit;
        mw_time_t    r;
        total = 14'(t.min) * 14'd60 + 14'(t.sec) + 14'(add_sec);
        limit = 14'(MAX_MIN) * 14'd60 + 14'(MAX_SEC);
        if (total > limit) begin
            r.min = MAX_MIN;
            r.sec = MAX_SEC;
        end else begin
            r.min = 7'(total / 14'd60);
            r.sec = 7'(total % 14'd60);
        end
        return r;
    endfunction

endpackage

// File: rtl/mw_sec_tick.sv
// Free-running one-second tick generator.
// Down-counter reloaded with TICK_COUNT-1; tick is high for the single cycle
// in which the counter sits at zero, giving one pulse every TICK_COUNT cycles.
// Ports:
//   clock  in   system clock
//   reset  in   asynchronous active-low reset
//   tick   out  1-cycle pulse once per TICK_COUNT cycles
module mw_sec_tick #(
    parameter int unsigned TICK_COUNT = 100_000_000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(TICK_COUNT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - CW'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/microwave_ctrl.sv
// Microwave cook sequencer.
// Turns panel buttons, door sensor and power setting into one-cycle timer
// commands and a clamped min:sec preset, duty-cycles the magnetron over a
// ten-second window, drives the cavity lamp and runs the end-of-cook beeper.
//
// Build option: define MW_CHILD_LOCK_EN to add the child_lock input, which
// blocks start/add in IDLE and start in PAUSED while high.
//
// Ports:
//   clock, reset                      clock, async active-low reset
//   btn_start/stop/pause/add          raw button levels (rising edge = press)
//   door_open                         1 = door open
//   child_lock                        (MW_CHILD_LOCK_EN only) lock start/add
//   power_sel[3:0]                    power 1..10, 0 or >10 means 10
//   sw_min[6:0], sw_sec[6:0]          preset switches
//   timer_done                        countdown finished pulse from timer
//   tmr_start/stop/pause              one-cycle commands to the timer
//   tmr_min[6:0], tmr_sec[6:0]        registered, clamped preset
//   magnetron, lamp, beep             heater, cavity light, buzzer
//   state[2:0]                        current FSM state
//
// state   | meaning
// IDLE    | preset editable, waiting for a valid start
// COOK    | timer running, magnetron duty-cycled
// PAUSED  | timer held, window position held
// FINISH  | beeper on for BEEP_SEC ticks or until any panel activity
module microwave_ctrl
    import mw_pkg::*;
#(
    parameter int unsigned TICK_COUNT   = 100_000_000,
    parameter int unsigned BEEP_SEC     = 3,
    parameter int unsigned ADD_STEP_SEC = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_pause,
    input  logic       btn_add,
    input  logic       door_open,
`ifdef MW_CHILD_LOCK_EN
    input  logic       child_lock,
`endif
    input  logic [3:0] power_sel,
    input  logic [6:0] sw_min,
    input  logic [6:0] sw_sec,
    input  logic       timer_done,
    output logic       tmr_start,
    output logic       tmr_stop,
    output logic       tmr_pause,
    output logic [6:0] tmr_min,
    output logic [6:0] tmr_sec,
    output logic       magnetron,
    output logic       lamp,
    output logic       beep,
    output logic [2:0] state
);

    localparam int unsigned BW = (BEEP_SEC > 1) ? $clog2(BEEP_SEC) : 1;
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_SEC - 1);
    localparam logic [6:0] ADD_STEP = 7'(ADD_STEP_SEC);

    logic tick;

    mw_sec_tick #(
        .TICK_COUNT(TICK_COUNT)
    ) u_sec_tick (
        .clock(clock),
        .reset(reset),
        .tick (tick)
    );

    logic lock;
`ifdef MW_CHILD_LOCK_EN
    assign lock = child_lock;
`else
    assign lock = 1'b0;
`endif

    // Button edges are registered so every command comes from a clean pulse.
    logic [3:0] btn_now;
    logic [3:0] btn_prev_q;
    logic [3:0] btn_edge_q;
    logic       ev_start;
    logic       ev_stop;
    logic       ev_pause;
    logic       ev_add;

    assign btn_now  = {btn_add, btn_pause, btn_stop, btn_start};
    assign ev_start = btn_edge_q[0];
    assign ev_stop  = btn_edge_q[1];
    assign ev_pause = btn_edge_q[2];
    assign ev_add   = btn_edge_q[3];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btn_prev_q <= '0;
            btn_edge_q <= '0;
        end else begin
            btn_prev_q <= btn_now;
            btn_edge_q <= btn_now & ~btn_prev_q;
        end
    end

    logic [3:0] eff_power;
    assign eff_power = (power_sel == 4'd0 || power_sel > 4'd10) ? 4'd10 : power_sel;

    mw_state_t     state_q, state_d;
    logic          add_mode_q, add_mode_d;
    mw_time_t      preset_q, preset_d;
    logic [3:0]    win_q, win_d;
    logic [BW-1:0] beep_cnt_q, beep_cnt_d;
    logic          tmr_start_q, tmr_start_d;
    logic          tmr_stop_q, tmr_stop_d;
    logic          tmr_pause_q, tmr_pause_d;
    logic          mag_q, mag_d;
    logic          lamp_q, lamp_d;
    logic          beep_q, beep_d;

    always_comb begin
        state_d     = state_q;
        add_mode_d  = add_mode_q;
        preset_d    = preset_q;
        win_d       = win_q;
        beep_cnt_d  = beep_cnt_q;
        tmr_start_d = 1'b0;
        tmr_stop_d  = 1'b0;
        tmr_pause_d = 1'b0;

        // The duty window keeps turning on a tick even if COOK is left this cycle.
        if (state_q == ST_COOK && tick) begin
            win_d = (win_q == 4'd9) ? 4'd0 : win_q + 4'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!add_mode_q) begin
                    preset_d = mw_clamp(sw_min, sw_sec);
                end
                // An ignored start does not swallow a simultaneous add.
                if (ev_stop) begin
                    add_mode_d = 1'b0;
                end else if (ev_start && !lock && !door_open && preset_q != '0) begin
                    tmr_start_d = 1'b1;
                    win_d       = 4'd0;
                    state_d     = ST_COOK;
                end else if (ev_add && !lock) begin
                    preset_d   = add_mode_q ? mw_sat_add(preset_q, ADD_STEP)
                                            : mw_sat_add('0, ADD_STEP);
                    add_mode_d = 1'b1;
                end
            end
            ST_COOK: begin
                if (ev_stop) begin
                    tmr_stop_d = 1'b1;
                    add_mode_d = 1'b0;
                    state_d    = ST_IDLE;
                end else if (door_open) begin
                    tmr_pause_d = 1'b1;
                    state_d     = ST_PAUSED;
                end else if (timer_done) begin
                    beep_cnt_d = '0;
                    add_mode_d = 1'b0;
                    state_d    = ST_FINISH;
                end else if (ev_pause) begin
                    tmr_pause_d = 1'b1;
                    state_d     = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (ev_stop) begin
                    tmr_stop_d = 1'b1;
                    add_mode_d = 1'b0;
                    state_d    = ST_IDLE;
                end else if (((ev_start && !lock) || ev_pause) && !door_open) begin
                    tmr_start_d = 1'b1;
                    state_d     = ST_COOK;
                end
            end
            ST_FINISH: begin
                if (ev_start || ev_stop || ev_pause || ev_add || door_open) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (beep_cnt_q == BEEP_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        beep_cnt_d = beep_cnt_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs follow the state being entered so they line up with it.
        mag_d  = (state_d == ST_COOK) && !door_open && (win_d < eff_power);
        lamp_d = door_open || (state_d == ST_COOK);
        beep_d = (state_d == ST_FINISH);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            add_mode_q  <= 1'b0;
            preset_q    <= '0;
            win_q       <= '0;
            beep_cnt_q  <= '0;
            tmr_start_q <= 1'b0;
            tmr_stop_q  <= 1'b0;
            tmr_pause_q <= 1'b0;
            mag_q       <= 1'b0;
            lamp_q      <= 1'b0;
            beep_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            add_mode_q  <= add_mode_d;
            preset_q    <= preset_d;
            win_q       <= win_d;
            beep_cnt_q  <= beep_cnt_d;
            tmr_start_q <= tmr_start_d;
            tmr_stop_q  <= tmr_stop_d;
            tmr_pause_q <= tmr_pause_d;
            mag_q       <= mag_d;
            lamp_q      <= lamp_d;
            beep_q      <= beep_d;
        end
    end

    assign tmr_start = tmr_start_q;
    assign tmr_stop  = tmr_stop_q;
    assign tmr_pause = tmr_pause_q;
    assign tmr_min   = preset_q.min;
    assign tmr_sec   = preset_q.sec;
    assign magnetron = mag_q;
    assign lamp      = lamp_q;
    assign beep      = beep_q;
    assign state     = state_q;

endmodule

// File: tb/tb_microwave_ctrl.sv
module tb_microwave_ctrl;

    localparam int TCK  = 10;
    localparam int BEEP = 3;
    localparam int ADD  = 30;

    logic       clock = 1'b0;
    logic       reset;
    logic       btn_start, btn_stop, btn_pause, btn_add;
    logic       door_open;
    logic [3:0] power_sel;
    logic [6:0] sw_min, sw_sec;
    logic       timer_done;
    logic       tmr_start, tmr_stop, tmr_pause;
    logic [6:0] tmr_min, tmr_sec;
    logic       magnetron, lamp, beep;
    logic [2:0] state;

    always #5 clock = ~clock;

    microwave_ctrl #(
        .TICK_COUNT  (TCK),
        .BEEP_SEC    (BEEP),
        .ADD_STEP_SEC(ADD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_stop  (btn_stop),
        .btn_pause (btn_pause),
        .btn_add   (btn_add),
        .door_open (door_open),
        .power_sel (power_sel),
        .sw_min    (sw_min),
        .sw_sec    (sw_sec),
        .timer_done(timer_done),
        .tmr_start (tmr_start),
        .tmr_stop  (tmr_stop),
        .tmr_pause (tmr_pause),
        .tmr_min   (tmr_min),
        .tmr_sec   (tmr_sec),
        .magnetron (magnetron),
        .lamp      (lamp),
        .beep      (beep),
        .state     (state)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: states 0 idle, 1 cook, 2 paused, 3 finish; preset in seconds.
    int m_state, m_min, m_sec, m_win, m_bcnt, m_k;
    bit m_add;
    bit pend_st, pend_sp, pend_pz, pend_ad;
    bit prev_st, prev_sp, prev_pz, prev_ad;
    bit x_ts, x_tt, x_tp, x_mag, x_lamp, x_beep;

    task automatic model_reset();
        m_state = 0; m_min = 0; m_sec = 0; m_win = 0; m_bcnt = 0; m_k = 0; m_add = 0;
        {pend_st, pend_sp, pend_pz, pend_ad} = 4'b0;
        {prev_st, prev_sp, prev_pz, prev_ad} = 4'b0;
        {x_ts, x_tt, x_tp, x_mag, x_lamp, x_beep} = 6'b0;
    endtask

    task automatic model_step();
        bit tick, any_btn;
        int ns, old_tot, t, p;
        tick = (m_k % TCK) == TCK - 1;
        m_k++;
        x_ts = 0; x_tt = 0; x_tp = 0;
        ns = m_state;
        old_tot = m_min * 60 + m_sec;
        any_btn = pend_st | pend_sp | pend_pz | pend_ad;
        if (m_state == 1 && tick) m_win = (m_win + 1) % 10;
        case (m_state)
            0: begin
                if (!m_add) begin
                    m_min = (int'(sw_min) > 99) ? 99 : int'(sw_min);
                    m_sec = (int'(sw_sec) > 59) ? 59 : int'(sw_sec);
                end
                if (pend_sp) m_add = 0;
                else if (pend_st && !door_open && old_tot != 0) begin
                    x_ts = 1; m_win = 0; ns = 1;
                end else if (pend_ad) begin
                    t = (m_add ? old_tot : 0) + ADD;
                    if (t > 99 * 60 + 59) t = 99 * 60 + 59;
                    m_min = t / 60; m_sec = t % 60; m_add = 1;
                end
            end
            1: begin
                if (pend_sp) begin x_tt = 1; m_add = 0; ns = 0; end
                else if (door_open) begin x_tp = 1; ns = 2; end
                else if (timer_done) begin m_bcnt = 0; m_add = 0; ns = 3; end
                else if (pend_pz) begin x_tp = 1; ns = 2; end
            end
            2: begin
                if (pend_sp) begin x_tt = 1; m_add = 0; ns = 0; end
                else if ((pend_st || pend_pz) && !door_open) begin x_ts = 1; ns = 1; end
            end
            default: begin
                if (any_btn || door_open) ns = 0;
                else if (tick) begin
                    m_bcnt++;
                    if (m_bcnt == BEEP) ns = 0;
                end
            end
        endcase
        p = (power_sel == 0 || power_sel > 10) ? 10 : int'(power_sel);
        x_mag  = (ns == 1) && !door_open && (m_win < p);
        x_lamp = door_open || (ns == 1);
        x_beep = (ns == 3);
        m_state = ns;
        pend_st = btn_start && !prev_st; prev_st = btn_start;
        pend_sp = btn_stop  && !prev_sp; prev_sp = btn_stop;
        pend_pz = btn_pause && !prev_pz; prev_pz = btn_pause;
        pend_ad = btn_add   && !prev_ad; prev_ad = btn_add;
    endtask

    task automatic compare_model();
        chk("state", int'(state), m_state);
        chk("tmr_start", int'(tmr_start), int'(x_ts));
        chk("tmr_stop", int'(tmr_stop), int'(x_tt));
        chk("tmr_pause", int'(tmr_pause), int'(x_tp));
        chk("tmr_min", int'(tmr_min), m_min);
        chk("tmr_sec", int'(tmr_sec), m_sec);
        chk("magnetron", int'(magnetron), int'(x_mag));
        chk("lamp", int'(lamp), int'(x_lamp));
        chk("beep", int'(beep), int'(x_beep));
    endtask

    task automatic cyc();
        @(posedge clock);
        if (reset) model_step();
        @(negedge clock);
        compare_model();
    endtask

    // which: 0 start, 1 stop, 2 pause, 3 add
    task automatic press(input int which);
        case (which)
            0: btn_start = 1'b1;
            1: btn_stop  = 1'b1;
            2: btn_pause = 1'b1;
            default: btn_add = 1'b1;
        endcase
        cyc();
        {btn_start, btn_stop, btn_pause, btn_add} = 4'b0;
        cyc();
    endtask

    typedef struct {
        logic [5:0] stim;   // start stop pause add door timer_done
        int         st;
        logic [5:0] exp;    // tmr_start tmr_stop tmr_pause magnetron lamp beep
    } vec_t;

    vec_t tbl [16];

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, rises, duty;
        bit pm;

        tbl[0]  = '{6'b000000, 0, 6'b000000};
        tbl[1]  = '{6'b100000, 0, 6'b000000};
        tbl[2]  = '{6'b100000, 1, 6'b100110};
        tbl[3]  = '{6'b000000, 1, 6'b000110};
        tbl[4]  = '{6'b001000, 1, 6'b000110};
        tbl[5]  = '{6'b000000, 2, 6'b001000};
        tbl[6]  = '{6'b000010, 2, 6'b000010};
        tbl[7]  = '{6'b100010, 2, 6'b000010};
        tbl[8]  = '{6'b000010, 2, 6'b000010};
        tbl[9]  = '{6'b000000, 2, 6'b000000};
        tbl[10] = '{6'b100000, 2, 6'b000000};
        tbl[11] = '{6'b000000, 1, 6'b100110};
        tbl[12] = '{6'b000001, 3, 6'b000001};
        tbl[13] = '{6'b000000, 3, 6'b000001};
        tbl[14] = '{6'b010000, 3, 6'b000001};
        tbl[15] = '{6'b000000, 0, 6'b000000};

        reset = 1'b0;
        {btn_start, btn_stop, btn_pause, btn_add, door_open, timer_done} = 6'b0;
        power_sel = 4'd10;
        sw_min = 7'd1;
        sw_sec = 7'd30;
        model_reset();
        repeat (3) @(negedge clock);
        chk("rst_state", int'(state), 0);
        chk("rst_cmds", int'({tmr_start, tmr_stop, tmr_pause}), 0);
        chk("rst_outs", int'({magnetron, lamp, beep}), 0);
        chk("rst_preset", int'({tmr_min, tmr_sec}), 0);
        reset = 1'b1;

        // Directed cook/pause/door/finish walk at power 10, preset 1:30.
        for (int i = 0; i < 16; i++) begin
            {btn_start, btn_stop, btn_pause, btn_add, door_open, timer_done} = tbl[i].stim;
            cyc();
            chk($sformatf("row%0d_state", i), int'(state), tbl[i].st);
            chk($sformatf("row%0d_outs", i),
                int'({tmr_start, tmr_stop, tmr_pause, magnetron, lamp, beep}), int'(tbl[i].exp));
            chk($sformatf("row%0d_min", i), int'(tmr_min), 1);
            chk($sformatf("row%0d_sec", i), int'(tmr_sec), 30);
        end
        {btn_start, btn_stop, btn_pause, btn_add, door_open, timer_done} = 6'b0;

        // Quick-add: three presses give 1:30, then walk up to saturation.
        sw_min = 7'd7;
        sw_sec = 7'd7;
        cyc();
        chk("track_sw", int'({tmr_min, tmr_sec}), int'({7'd7, 7'd7}));
        repeat (3) press(3);
        chk("add3_min", int'(tmr_min), 1);
        chk("add3_sec", int'(tmr_sec), 30);
        repeat (196) press(3);
        chk("add199_min", int'(tmr_min), 99);
        chk("add199_sec", int'(tmr_sec), 30);
        press(3);
        chk("sat_min", int'(tmr_min), 99);
        chk("sat_sec", int'(tmr_sec), 59);
        press(3);
        chk("sat_hold", int'({tmr_min, tmr_sec}), int'({7'd99, 7'd59}));

        // Power 3 duty over one full 10-tick window, including the 9->0 wrap.
        press(1);
        sw_min = 7'd10;
        sw_sec = 7'd0;
        power_sel = 4'd3;
        cyc();
        press(0);
        chk("p3_start", int'(tmr_start), 1);
        chk("p3_state", int'(state), 1);
        duty = 0;
        rises = 0;
        pm = magnetron;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (magnetron) duty++;
            if (magnetron && !pm) rises++;
            pm = magnetron;
        end
        chk("p3_duty", duty, 30);
        chk("p3_wrap_rises", rises, 1);

        // Door opened while cooking, start with door open, then resume.
        door_open = 1'b1;
        cyc();
        chk("door_pause", int'(tmr_pause), 1);
        chk("door_state", int'(state), 2);
        chk("door_mag_lamp", int'({magnetron, lamp}), 1);
        cyc();
        chk("door_pause_once", int'(tmr_pause), 0);
        press(0);
        chk("door_start_ign", int'({tmr_start, state}), 2);
        door_open = 1'b0;
        press(0);
        chk("resume_start", int'(tmr_start), 1);
        chk("resume_state", int'(state), 1);

        // Stop and timer_done on the same edge: stop wins, no beep.
        btn_stop = 1'b1;
        cyc();
        btn_stop = 1'b0;
        timer_done = 1'b1;
        cyc();
        timer_done = 1'b0;
        chk("stopdone_stop", int'(tmr_stop), 1);
        chk("stopdone_state", int'(state), 0);
        chk("stopdone_beep", int'(beep), 0);

        // Natural end of cook: beep for BEEP ticks then back to IDLE.
        press(0);
        timer_done = 1'b1;
        cyc();
        timer_done = 1'b0;
        chk("fin_state", int'(state), 3);
        chk("fin_beep", int'(beep), 1);
        n = 1;
        for (int i = 0; i < 100 && beep; i++) begin
            cyc();
            if (beep) n++;
        end
        chk("beep_len_ok", int'(n > (BEEP - 1) * TCK && n <= BEEP * TCK), 1);
        chk("fin_idle", int'(state), 0);

        // Reset mid-cook clears everything immediately.
        power_sel = 4'd10;
        press(0);
        chk("rc_mag_on", int'(magnetron), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("rc_mag", int'(magnetron), 0);
        chk("rc_cmds", int'({tmr_start, tmr_stop, tmr_pause}), 0);
        chk("rc_beep_lamp", int'({beep, lamp}), 0);
        chk("rc_state", int'(state), 0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        cyc();
        chk("rc_idle_after", int'(state), 0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            btn_start  = ($urandom_range(5) == 0);
            btn_pause  = ($urandom_range(11) == 0);
            btn_add    = ($urandom_range(7) == 0);
            btn_stop   = ($urandom_range(19) == 0);
            timer_done = ($urandom_range(29) == 0);
            if ($urandom_range(24) == 0) door_open = ~door_open;
            if ($urandom_range(49) == 0) power_sel = 4'($urandom_range(15));
            if ($urandom_range(39) == 0) begin
                sw_min = 7'($urandom_range(127));
                sw_sec = 7'($urandom_range(127));
            end
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
